// File: rtl/port_rx_buffer_pkg.sv
// Shared definitions for the per-port receive buffer: frame limits, descriptor layout,
// CRC-32 constants and the receive FSM encoding.
package port_rx_buffer_pkg;

    localparam int MAX_FRAME_DEF  = 1518;
    localparam int MIN_FRAME_DEF  = 64;
    localparam int DATA_DEPTH_DEF = 4096;
    localparam int PTR_DEPTH      = 32;

    localparam int CRC_ERR_BIT = 15;
    localparam int FRM_ERR_BIT = 14;
    localparam int LEN_MSB     = 10;

    // The engine shifts LSB-first, so the residue is compared after bit reversal.
    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REF = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704_DD7B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2,
        CMMT = 2'd3
    } rx_state_e;

    function automatic logic [15:0] satInc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] bitRev32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/port_rx_buffer_if.sv
// MAC receive stream plus the arbiter-facing read side of one port's receive buffer.
interface port_rx_buffer_if;

    logic        rx_dv;
    logic [7:0]  rx_d;
    logic        rx_er;
    logic        rx_data_fifo_rd;
    logic [7:0]  rx_data_fifo_dout;
    logic        rx_ptr_fifo_rd;
    logic [15:0] rx_ptr_fifo_dout;
    logic        rx_ptr_fifo_empty;

    modport slave (
        input  rx_dv, rx_d, rx_er, rx_data_fifo_rd, rx_ptr_fifo_rd,
        output rx_data_fifo_dout, rx_ptr_fifo_dout, rx_ptr_fifo_empty
    );

    modport master (
        output rx_dv, rx_d, rx_er, rx_data_fifo_rd, rx_ptr_fifo_rd,
        input  rx_data_fifo_dout, rx_ptr_fifo_dout, rx_ptr_fifo_empty
    );

endinterface

// File: rtl/port_rx_buffer_crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32; only used when
// RX_CRC_CHECK_EN is defined.
module crc32_d8
    import port_rx_buffer_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        logic [31:0] c;
        c = crc_i ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REF) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/port_rx_buffer_fifo.sv
// Synchronous FIFO with registered read data and an occupancy count; reads while empty
// and writes while full are ignored. DEPTH must be a power of two.
module port_rx_buffer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] dout_q;
    logic             doWr;
    logic             doRd;

    assign doWr = wr_en_i && (count_q != CW'(DEPTH));
    assign doRd = rd_en_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (doWr) begin
            mem_q[wrPtr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            if (doWr) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doRd) begin
                rdPtr_q <= rdPtr_q + AW'(1);
                dout_q  <= mem_q[rdPtr_q];
            end
            count_q <= count_q + CW'(doWr) - CW'(doRd);
        end
    end

    assign dout_o  = dout_q;
    assign count_o = count_q;

endmodule

// File: rtl/port_rx_buffer.sv
// Per-port receive buffer: admits, length-checks and stores MAC frames, then commits one
// descriptor per frame. Define RX_CRC_CHECK_EN to flag FCS errors in descriptor bit 15.
module port_rx_buffer
    import port_rx_buffer_pkg::*;
#(
    parameter int MAX_FRAME  = MAX_FRAME_DEF,
    parameter int MIN_FRAME  = MIN_FRAME_DEF,
    parameter int DATA_DEPTH = DATA_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    port_rx_buffer_if.slave rx,
    output logic [15:0]     frame_cnt,
    output logic [15:0]     drop_cnt
);

    localparam int DCW = $clog2(DATA_DEPTH) + 1;
    localparam int PCW = $clog2(PTR_DEPTH) + 1;
    localparam int LW  = LEN_MSB + 1;
    // Headroom of two covers the byte still sitting in the write register.
    localparam logic [DCW-1:0] ADMIT_LIMIT  = DCW'(DATA_DEPTH - MAX_FRAME - 2);
    localparam logic [PCW-1:0] PTR_FULL_CNT = PCW'(PTR_DEPTH);
    localparam logic [LW-1:0]  MAX_LEN      = LW'(MAX_FRAME);
    localparam logic [LW-1:0]  MIN_LEN      = LW'(MIN_FRAME);

    rx_state_e      state_q, state_d;
    logic [LW-1:0]  len_q, len_d;
    logic           tooLong_q, tooLong_d;
    logic           phyErr_q, phyErr_d;
    logic           dataWrEn_q, dataWrEn_d;
    logic [7:0]     dataDin_q, dataDin_d;
    logic [15:0]    frameCnt_q, frameCnt_d;
    logic [15:0]    dropCnt_q, dropCnt_d;
    logic [DCW-1:0] dataCount;
    logic [PCW-1:0] ptrCount;
    logic           admit;
    logic           ptrWrEn;
    logic           crcErr;
    logic           frameErr;
    logic [15:0]    desc;

    assign admit = (dataCount <= ADMIT_LIMIT) && (ptrCount != PTR_FULL_CNT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            len_q      <= '0;
            tooLong_q  <= 1'b0;
            phyErr_q   <= 1'b0;
            dataWrEn_q <= 1'b0;
            dataDin_q  <= '0;
            frameCnt_q <= '0;
            dropCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            tooLong_q  <= tooLong_d;
            phyErr_q   <= phyErr_d;
            dataWrEn_q <= dataWrEn_d;
            dataDin_q  <= dataDin_d;
            frameCnt_q <= frameCnt_d;
            dropCnt_q  <= dropCnt_d;
        end
    end

    // len counts only bytes really written, so it saturates at MAX_LEN and never wraps.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        tooLong_d  = tooLong_q;
        phyErr_d   = phyErr_q;
        dataWrEn_d = 1'b0;
        dataDin_d  = dataDin_q;
        frameCnt_d = frameCnt_q;
        dropCnt_d  = dropCnt_q;
        ptrWrEn    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx.rx_dv) begin
                    if (admit) begin
                        state_d    = RECV;
                        dataWrEn_d = 1'b1;
                        dataDin_d  = rx.rx_d;
                        len_d      = LW'(1);
                        phyErr_d   = rx.rx_er;
                    end else begin
                        state_d   = DROP;
                        dropCnt_d = satInc16(dropCnt_q);
                    end
                end
            end
            RECV: begin
                if (rx.rx_dv) begin
                    if (len_q < MAX_LEN) begin
                        dataWrEn_d = 1'b1;
                        dataDin_d  = rx.rx_d;
                        len_d      = len_q + LW'(1);
                    end else begin
                        tooLong_d = 1'b1;
                    end
                    if (rx.rx_er) begin
                        phyErr_d = 1'b1;
                    end
                end else begin
                    state_d = CMMT;
                end
            end
            CMMT: begin
                ptrWrEn    = 1'b1;
                frameCnt_d = satInc16(frameCnt_q);
                len_d      = '0;
                tooLong_d  = 1'b0;
                phyErr_d   = 1'b0;
                if (rx.rx_dv) begin
                    state_d   = DROP;
                    dropCnt_d = satInc16(dropCnt_q);
                end else begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (!rx.rx_dv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef RX_CRC_CHECK_EN
    logic [31:0] crc_q;
    logic [31:0] crcNext;
    logic        crcStep;

    assign crcStep = rx.rx_dv && ((state_q == RECV) || ((state_q == IDLE) && admit));

    crc32_d8 uCrc (
        .crc_i  (crc_q),
        .data_i (rx.rx_d),
        .crc_o  (crcNext)
    );

    // Runs over truncated bytes too, so an over-long frame still gets a meaningful check.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc_q <= CRC_INIT;
        end else if (state_q == CMMT) begin
            crc_q <= CRC_INIT;
        end else if (crcStep) begin
            crc_q <= crcNext;
        end
    end

    assign crcErr = (bitRev32(crc_q) != CRC_RESIDUE);
`else
    assign crcErr = 1'b0;
`endif

    assign frameErr = (len_q < MIN_LEN) || tooLong_q || phyErr_q;

    always_comb begin
        desc              = '0;
        desc[CRC_ERR_BIT] = crcErr;
        desc[FRM_ERR_BIT] = frameErr;
        desc[LEN_MSB:0]   = len_q;
    end

    port_rx_buffer_fifo #(
        .WIDTH (8),
        .DEPTH (DATA_DEPTH),
        .CW    (DCW)
    ) uDataFifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en_i (dataWrEn_q),
        .din_i   (dataDin_q),
        .rd_en_i (rx.rx_data_fifo_rd),
        .dout_o  (rx.rx_data_fifo_dout),
        .count_o (dataCount)
    );

    port_rx_buffer_fifo #(
        .WIDTH (16),
        .DEPTH (PTR_DEPTH),
        .CW    (PCW)
    ) uPtrFifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en_i (ptrWrEn),
        .din_i   (desc),
        .rd_en_i (rx.rx_ptr_fifo_rd),
        .dout_o  (rx.rx_ptr_fifo_dout),
        .count_o (ptrCount)
    );

    assign rx.rx_ptr_fifo_empty = (ptrCount == '0);
    assign frame_cnt            = frameCnt_q;
    assign drop_cnt             = dropCnt_q;

endmodule

// File: tb/tb_port_rx_buffer.sv
// Scoreboard bench for port_rx_buffer: stimulus queues expected descriptors and bytes,
// a monitor drains both FIFOs and compares.
module tb_port_rx_buffer;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    port_rx_buffer_if ifc();

    port_rx_buffer dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (ifc),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int          checks    = 0;
    int          errors    = 0;
    bit          monEnable = 1'b0;
    logic [15:0] expDesc[$];
    logic [7:0]  expData[$];
    logic [7:0]  frameBuf[$];

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) begin
            if (r[0]) r = (r >> 1) ^ 32'hEDB8_8320;
            else      r = r >> 1;
        end
        return r;
    endfunction

    // Payload of len-4 bytes followed by a correct FCS, optionally with one FCS bit flipped.
    task automatic buildFrame(input int len, input int seed, input bit flipFcs);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        frameBuf.delete();
        for (int i = 0; i < len - 4; i++) begin
            b = 8'(seed * 31 + i * 13);
            frameBuf.push_back(b);
            c = crcByte(c, b);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) begin
            frameBuf.push_back(c[8*k +: 8]);
        end
        if (flipFcs) frameBuf[len-1] = frameBuf[len-1] ^ 8'h01;
    endtask

    task automatic pushExpect(input logic [15:0] desc, input int first, input int count);
        expDesc.push_back(desc);
        for (int i = first; i < first + count; i++) begin
            expData.push_back(frameBuf[i]);
        end
    endtask

    task automatic applyStimulus(input int first, input int last, input int erIdx, input int gap);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            ifc.rx_dv = 1'b1;
            ifc.rx_d  = frameBuf[i];
            ifc.rx_er = (i == erIdx);
        end
        @(negedge clk);
        ifc.rx_dv = 1'b0;
        ifc.rx_d  = 8'h00;
        ifc.rx_er = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic waitDrain(input string name);
        int budget;
        budget = 20000;
        while ((expDesc.size() != 0 || expData.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("[TB] FAIL drain_%s: got %0d descriptors / %0d bytes outstanding, expected 0 / 0",
                     name, expDesc.size(), expData.size());
            expDesc.delete();
            expData.delete();
        end
        repeat (4) @(negedge clk);
        checkOutput({"ptr_empty_after_", name}, 32'(ifc.rx_ptr_fifo_empty), 32'd1);
    endtask

    // Monitor: pulls each descriptor, then the bytes it announces.
    initial begin
        logic [15:0] gotDesc;
        int          n;
        ifc.rx_ptr_fifo_rd  = 1'b0;
        ifc.rx_data_fifo_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (monEnable && rstn === 1'b1 && ifc.rx_ptr_fifo_empty === 1'b0) begin
                ifc.rx_ptr_fifo_rd = 1'b1;
                @(negedge clk);
                ifc.rx_ptr_fifo_rd = 1'b0;
                gotDesc = ifc.rx_ptr_fifo_dout;
                if (expDesc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_descriptor: got 0x%0h, expected none", gotDesc);
                    n = int'(gotDesc[10:0]);
                end else begin
                    logic [15:0] wantDesc;
                    wantDesc = expDesc.pop_front();
                    checkOutput("descriptor", 32'(gotDesc), 32'(wantDesc));
                    n = int'(wantDesc[10:0]);
                end
                for (int i = 0; i < n; i++) begin
                    ifc.rx_data_fifo_rd = 1'b1;
                    @(negedge clk);
                    ifc.rx_data_fifo_rd = 1'b0;
                    if (expData.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_data: got 0x%0h, expected none",
                                 ifc.rx_data_fifo_dout);
                    end else begin
                        checkOutput("data_byte", 32'(ifc.rx_data_fifo_dout), 32'(expData.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ifc.rx_dv = 1'b0;
        ifc.rx_d  = 8'h00;
        ifc.rx_er = 1'b0;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ptr_empty", 32'(ifc.rx_ptr_fifo_empty), 32'd1);
        checkOutput("reset_ptr_dout", 32'(ifc.rx_ptr_fifo_dout), 32'd0);
        checkOutput("reset_data_dout", 32'(ifc.rx_data_fifo_dout), 32'd0);
        checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        rstn      = 1'b1;
        monEnable = 1'b1;
        @(negedge clk);

        $display("[TB] good 64-byte frame");
        buildFrame(64, 1, 1'b0);
        pushExpect(16'h0040, 0, 64);
        applyStimulus(0, 63, -1, 2);
        waitDrain("good64");
        checkOutput("frame_cnt_good64", 32'(frame_cnt), 32'd1);

        $display("[TB] 64-byte frame with flipped FCS bit");
        buildFrame(64, 2, 1'b1);
`ifdef RX_CRC_CHECK_EN
        pushExpect(16'h8040, 0, 64);
`else
        pushExpect(16'h0040, 0, 64);
`endif
        applyStimulus(0, 63, -1, 2);
        waitDrain("badfcs");

        $display("[TB] 1600-byte frame followed by a 64-byte frame");
        buildFrame(1600, 3, 1'b0);
        pushExpect(16'h45EE, 0, 1518);
        applyStimulus(0, 1599, -1, 2);
        buildFrame(64, 4, 1'b0);
        pushExpect(16'h0040, 0, 64);
        applyStimulus(0, 63, -1, 2);
        waitDrain("long");

        $display("[TB] runt and PHY-error frames");
        buildFrame(40, 5, 1'b0);
        pushExpect(16'h4028, 0, 40);
        applyStimulus(0, 39, -1, 2);
        buildFrame(100, 6, 1'b0);
        pushExpect(16'h4064, 0, 100);
        applyStimulus(0, 99, 50, 2);
        waitDrain("errors");
        checkOutput("frame_cnt_errors", 32'(frame_cnt), 32'd6);
        checkOutput("drop_cnt_errors", 32'(drop_cnt), 32'd0);

        $display("[TB] fill data FIFO without reads");
        monEnable = 1'b0;
        for (int f = 0; f < 3; f++) begin
            buildFrame(900, 7 + f, 1'b0);
            pushExpect(16'h0384, 0, 900);
            applyStimulus(0, 899, -1, 2);
        end
        buildFrame(900, 10, 1'b0);
        applyStimulus(0, 899, -1, 2);
        checkOutput("drop_cnt_fill", 32'(drop_cnt), 32'd1);
        checkOutput("frame_cnt_fill", 32'(frame_cnt), 32'd9);
        checkOutput("ptr_empty_fill", 32'(ifc.rx_ptr_fifo_empty), 32'd0);
        monEnable = 1'b1;
        waitDrain("fill");
        buildFrame(64, 11, 1'b0);
        pushExpect(16'h0040, 0, 64);
        applyStimulus(0, 63, -1, 2);
        waitDrain("after_fill");
        checkOutput("frame_cnt_after_fill", 32'(frame_cnt), 32'd10);

        $display("[TB] frame arriving during commit cycle");
        buildFrame(64, 12, 1'b0);
        pushExpect(16'h0040, 0, 64);
        applyStimulus(0, 63, -1, 1);
        buildFrame(64, 13, 1'b0);
        applyStimulus(0, 63, -1, 2);
        waitDrain("nogap");
        checkOutput("drop_cnt_nogap", 32'(drop_cnt), 32'd2);
        checkOutput("frame_cnt_nogap", 32'(frame_cnt), 32'd11);

        $display("[TB] reset pulse mid-frame");
        monEnable = 1'b0;
        buildFrame(100, 14, 1'b0);
`ifdef RX_CRC_CHECK_EN
        pushExpect(16'h8044, 32, 68);
`else
        pushExpect(16'h0044, 32, 68);
`endif
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 31) begin
                checkOutput("midreset_ptr_empty", 32'(ifc.rx_ptr_fifo_empty), 32'd1);
                checkOutput("midreset_frame_cnt", 32'(frame_cnt), 32'd0);
                checkOutput("midreset_drop_cnt", 32'(drop_cnt), 32'd0);
                checkOutput("midreset_ptr_dout", 32'(ifc.rx_ptr_fifo_dout), 32'd0);
            end
            if (i == 30) rstn = 1'b0;
            if (i == 32) rstn = 1'b1;
            ifc.rx_dv = 1'b1;
            ifc.rx_d  = frameBuf[i];
            ifc.rx_er = 1'b0;
        end
        @(negedge clk);
        ifc.rx_dv = 1'b0;
        ifc.rx_d  = 8'h00;
        @(negedge clk);
        monEnable = 1'b1;
        waitDrain("reset_resume");
        checkOutput("frame_cnt_reset_resume", 32'(frame_cnt), 32'd1);
        buildFrame(64, 15, 1'b0);
        pushExpect(16'h0040, 0, 64);
        applyStimulus(0, 63, -1, 2);
        waitDrain("post_reset");
        checkOutput("frame_cnt_post_reset", 32'(frame_cnt), 32'd2);
        checkOutput("drop_cnt_post_reset", 32'(drop_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/port_rx_buffer.md
# port_rx_buffer

Per-port receive buffer that sits directly upstream of the 4-port ingress arbiter. It takes the byte stream of one MAC receive port, counts and checks each frame, stores the bytes in a per-port data FIFO and, at end of frame, commits one 16-bit frame descriptor to a per-port pointer FIFO. The arbiter drains both FIFOs through the read-side ports. One instance is built per switch port.

## Interface
- MAX_FRAME, 1518, largest legal frame in bytes (DA..FCS); longer frames are truncated.
- MIN_FRAME, 64, smallest legal frame in bytes.
- DATA_DEPTH, 4096, data FIFO depth in bytes; must be ≥ 2*MAX_FRAME.
- clk  in  1  core clock; MAC side is already synchronous to it.
- rstn  in  1  reset, asynchronous, active-low.
- rx_dv  in  1  frame valid; high for every byte from DA through FCS, preamble/SFD already stripped.
- rx_d  in  8  frame byte, valid when rx_dv=1.
- rx_er  in  1  PHY error, sampled only while rx_dv=1.
- rx_data_fifo_rd  in  1  data FIFO read strobe.
- rx_data_fifo_dout  out  8  data FIFO read data.
- rx_ptr_fifo_rd  in  1  pointer FIFO read strobe.
- rx_ptr_fifo_dout  out  16  descriptor: [15] crc_err, [14] frame_err, [13:11] 0, [10:0] byte count stored.
- rx_ptr_fifo_empty  out  1  pointer FIFO empty.
- frame_cnt  out  16  committed descriptors, saturating.
- drop_cnt  out  16  frames dropped for lack of space, saturating.

## Operation
- FSM states: IDLE, RECV, DROP, CMMT.
- IDLE: on rx_dv=1, admit if data_count ≤ DATA_DEPTH−MAX_FRAME−2 and pointer FIFO not full → RECV, writing the current byte; otherwise → DROP and increment drop_cnt.
- RECV: each rx_dv=1 byte increments len (11 bit). The byte is written while len < MAX_FRAME. Beyond that it is discarded and the too-long flag is set. rx_er=1 sets the phy flag. rx_dv=0 → CMMT.
- CMMT: one-cycle pointer FIFO write of {crc_err, frame_err, 3'b0, len_stored}.
  - frame_err = (len < MIN_FRAME) | too_long | phy.
  - len_stored = bytes actually in the data FIFO (≤ MAX_FRAME). The downstream reader trusts this count exactly.
  - Increment frame_cnt. Clear len and flags. → IDLE.
- DROP: nothing written; stays until rx_dv=0 → IDLE.
- rx_dv=1 during CMMT (no gap): that frame goes to DROP, drop_cnt increments. The committing descriptor is unaffected.
- Errored frames are still stored and committed; discard is the reader's job.
- Reset mid-frame: FIFOs, FSM, counters and flags cleared. A partial frame is lost. Bytes that continue after reset deasserts, with rx_dv still high, are treated as a new frame start.

## Timing
- Data write: byte sampled at edge N is written (wr_en, din registered) at edge N+1.
- Last byte sampled at edge N, rx_dv=0 at N+1 → CMMT at N+1 → pointer wr_en high for cycle N+1..N+2. Descriptor is readable, empty=0, one cycle later by FIFO latency.
- Read side follows the FIFO primitive: first-word latency one cycle after rd.
- Counters saturate at 0xFFFF and never wrap.
- Reset values: rx_ptr_fifo_empty=1, rx_ptr_fifo_dout=0, rx_data_fifo_dout=0, frame_cnt=0, drop_cnt=0; internal wr_en=0, FSM=IDLE.
- Reads while empty are ignored by the FIFO.

## Configuration
- RX_CRC_CHECK_EN defined: CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over every received byte including FCS and truncated bytes. crc_err = residue ≠ 0xC704DD7B, evaluated in CMMT.
- Not defined: no CRC logic; bit 15 always 0.

## Structure
- Shared package: MAX_FRAME/MIN_FRAME defaults, descriptor bit positions (CRC_ERR_BIT=15, FRM_ERR_BIT=14, LEN_MSB=10), CRC residue constant, FSM state encoding.
- Sub-module: crc32_d8, combinational next-CRC for one byte, instantiated only under RX_CRC_CHECK_EN.
- Existing FIFO primitives: data FIFO w8 × DATA_DEPTH with data_count; pointer FIFO w16 × 32.

## Test plan
- 64-byte frame with correct FCS → descriptor 0x0040, 64 bytes read back in order, frame_cnt=1.
- Same frame with one FCS bit flipped (RX_CRC_CHECK_EN) → descriptor 0x8040; without the macro → 0x0040.
- 1600-byte frame → descriptor 0x45EE, exactly 1518 bytes stored, next frame's first byte follows directly.
- 40-byte runt → 0x4028; 100-byte frame with rx_er on byte 50 → 0x4064.
- Data FIFO filled with no reads until data_count > 2576 → next frame dropped, drop_cnt=1, no descriptor. After draining, next frame is accepted.
- rstn pulsed low mid-frame → empty=1, counters 0. Following full frame commits correctly.
